// File: rtl/guess_game_ctrl_pkg.sv
// Shared types and constants for the keypad guessing game controller.
package guess_game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        CHECK = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } state_e;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_NEW   = 4'hF;
    localparam logic [3:0] BLANK     = 4'hF;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_LOW  = 2'b01;
    localparam logic [1:0] RES_HIGH = 2'b10;
    localparam logic [1:0] RES_WIN  = 2'b11;

    function automatic logic [7:0] bcd2(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/guess_game_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// Guessing game sequencer: key events in, BCD display data out.
// Define GUESS_HINT_EN to report too-high (10) separately from too-low.
module guess_game_ctrl
    import guess_game_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 10,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic        clk_50M,
    input  logic        RSTn,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] disp_data,
    output logic [7:0]  tries,
    output logic [1:0]  result,
    output logic [2:0]  state_o,
    output logic        game_over
);

    localparam logic [6:0] MT7 = 7'(MAX_TRIES);

    state_e      state_q, state_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic        fresh_q, fresh_d;
    logic [6:0]  tries_q, tries_d;
    logic [1:0]  result_q, result_d;
    logic [6:0]  secret_q, secret_d;
    logic [15:0] disp_q, disp_d;
    logic        over_q, over_d;

    logic [7:0]  lfsr;
    logic        unused_lfsr_msb;
    logic [6:0]  new_secret;
    logic [6:0]  guess_val;
    logic [6:0]  tries_inc;
    logic [1:0]  wrong_res;
    logic        is_digit;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk_i  (clk_50M),
        .rst_i  (RSTn),
        .lfsr_o (lfsr)
    );

    assign unused_lfsr_msb = lfsr[7];
    assign new_secret = (lfsr[6:0] >= 7'd100) ? lfsr[6:0] - 7'd100 : lfsr[6:0];
    assign is_digit   = (key_code <= 4'd9);
    // A blank tens digit counts as zero.
    assign guess_val  = ((tens_q == BLANK) ? 7'd0 : {3'b0, tens_q} * 7'd10)
                      + {3'b0, ones_q};
    assign tries_inc  = (tries_q >= MT7) ? MT7 : tries_q + 7'd1;

`ifdef GUESS_HINT_EN
    assign wrong_res = (guess_val < secret_q) ? RES_LOW : RES_HIGH;
`else
    assign wrong_res = RES_LOW;
`endif

    always_comb begin
        state_d  = state_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        fresh_d  = fresh_q;
        tries_d  = tries_q;
        result_d = result_q;
        secret_d = secret_q;
        if (state_q == CHECK) begin
            tries_d = tries_inc;
            fresh_d = 1'b1;
            if (guess_val == secret_q) begin
                result_d = RES_WIN;
                state_d  = WIN;
            end else begin
                result_d = wrong_res;
                state_d  = (tries_inc == MT7) ? LOSE : ENTRY;
            end
        end else if (key_valid && key_code == KEY_NEW) begin
            state_d  = ENTRY;
            secret_d = new_secret;
            tens_d   = BLANK;
            ones_d   = BLANK;
            fresh_d  = 1'b0;
            tries_d  = '0;
            result_d = RES_NONE;
        end else if (state_q == ENTRY && key_valid) begin
            unique case (1'b1)
                is_digit: begin
                    tens_d  = fresh_q ? BLANK : ones_q;
                    ones_d  = key_code;
                    fresh_d = 1'b0;
                end
                (key_code == KEY_CLEAR): begin
                    tens_d  = BLANK;
                    ones_d  = BLANK;
                    fresh_d = 1'b0;
                end
                (key_code == KEY_ENTER): begin
                    if (ones_q != BLANK) state_d = CHECK;
                end
                default: ;
            endcase
        end
    end

    // Display is built from next-state values so it lands with the state.
    assign disp_d[15:8] = (state_d == IDLE) ? {BLANK, BLANK} : bcd2(tries_d);
    assign disp_d[7:0]  = (state_d == LOSE) ? bcd2(secret_d) : {tens_d, ones_d};
    assign over_d       = (state_d == WIN) || (state_d == LOSE);

    always_ff @(posedge clk_50M) begin
        if (RSTn) begin
            state_q  <= IDLE;
            tens_q   <= BLANK;
            ones_q   <= BLANK;
            fresh_q  <= 1'b0;
            tries_q  <= '0;
            result_q <= RES_NONE;
            secret_q <= '0;
            disp_q   <= 16'hFFFF;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            fresh_q  <= fresh_d;
            tries_q  <= tries_d;
            result_q <= result_d;
            secret_q <= secret_d;
            disp_q   <= disp_d;
            over_q   <= over_d;
        end
    end

    assign disp_data = disp_q;
    assign tries     = {1'b0, tries_q};
    assign result    = result_q;
    assign state_o   = state_q;
    assign game_over = over_q;

endmodule
